grad_matrix_3x3: RTL and testbench

- Producer side of the 3x3 gradient-window interface consumed by non-maximum suppression.
- Accepts a raster stream of packed gradient words {dir[1:0], mag[23:0]} from the Sobel/direction stage.
- Buffers two previous rows in line buffers and emits nine window taps grad_p11..grad_p33, with matrix_clken, data_valid (1 = invalid border window) and start_sync aligned to the taps.

---
 rtl/grad_matrix_3x3.sv | 143 ++++++++++++++
 tb/tb_grad_matrix_3x3.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_matrix_3x3.sv
// 3x3 gradient-window generator: two line buffers plus a column shift window over a raster stream.
// Optional macro GRAD_MATRIX_ZERO_INVALID_EN forces all taps to zero on border (data_valid=1) strobes.
module grad_matrix_3x3 #(
  parameter int WIDTH       = 634,
  parameter int DEPTH       = 506,
  parameter int FIFO_SUM    = 2,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] grad_p11,
  output logic [DATA_WIDTH-1:0] grad_p12,
  output logic [DATA_WIDTH-1:0] grad_p13,
  output logic [DATA_WIDTH-1:0] grad_p21,
  output logic [DATA_WIDTH-1:0] grad_p22,
  output logic [DATA_WIDTH-1:0] grad_p23,
  output logic [DATA_WIDTH-1:0] grad_p31,
  output logic [DATA_WIDTH-1:0] grad_p32,
  output logic [DATA_WIDTH-1:0] grad_p33,
  output logic                  matrix_clken,
  output logic                  data_valid,
  output logic                  start_sync,
  output logic                  frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(DEPTH);
`ifdef GRAD_MATRIX_ZERO_INVALID_EN
  localparam bit ZERO_INVALID = 1'b1;
`else
  localparam bit ZERO_INVALID = 1'b0;
`endif

  logic [CW-1:0]         col_cnt_p0;
  logic [RW-1:0]         row_cnt_p0;
  logic                  acc_p0;
  logic                  col_last_p0;
  logic                  row_last_p0;
  logic                  rows_full_p0;
  logic                  border_p0;
  // lb[0] holds row r-1, lb[1] holds row r-2
  logic [DATA_WIDTH-1:0] lb [FIFO_SUM][WIDTH];
  logic [DATA_WIDTH-1:0] col_new_p0 [KERNEL_SIZE];
  // shift window indexed [column][row]; column 0 is the oldest
  logic [DATA_WIDTH-1:0] sh_p0   [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] sh_n_p0 [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] win_p1  [KERNEL_SIZE][KERNEL_SIZE];
  logic                  vld_p1;
  logic                  inv_p1;
  logic                  start_p1;
  logic                  done_p1;

  always_comb begin
    acc_p0        = start && in_en;
    col_last_p0   = (col_cnt_p0 == CW'(WIDTH - 1));
    row_last_p0   = (row_cnt_p0 == RW'(DEPTH - 1));
    rows_full_p0  = (row_cnt_p0 >= RW'(FIFO_SUM));
    border_p0     = (col_cnt_p0 < CW'(KERNEL_SIZE - 1));
    col_new_p0[0] = lb[1][col_cnt_p0];
    col_new_p0[1] = lb[0][col_cnt_p0];
    col_new_p0[2] = in_data;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        sh_n_p0[k][j] = (k == KERNEL_SIZE - 1) ? col_new_p0[j] : sh_p0[(k + 1) % KERNEL_SIZE][j];
      end
    end
  end

  // Line buffers: old contents are read combinationally above, so the write below is read-before-write.
  always_ff @(posedge clk) begin
    if (acc_p0 && !rst) begin
      lb[1][col_cnt_p0] <= lb[0][col_cnt_p0];
      lb[0][col_cnt_p0] <= in_data;
    end
  end

  // Stage p0 -> p1: counters, window shift and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_p0 <= '0;
      row_cnt_p0 <= '0;
      vld_p1     <= 1'b0;
      inv_p1     <= 1'b0;
      start_p1   <= 1'b0;
      done_p1    <= 1'b0;
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        for (int j = 0; j < KERNEL_SIZE; j++) begin
          sh_p0[k][j]  <= '0;
          win_p1[k][j] <= '0;
        end
      end
    end else begin
      start_p1 <= start;
      vld_p1   <= 1'b0;
      inv_p1   <= 1'b0;
      done_p1  <= 1'b0;
      if (!start) begin
        col_cnt_p0 <= '0;
        row_cnt_p0 <= '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
          for (int j = 0; j < KERNEL_SIZE; j++) begin
            sh_p0[k][j] <= '0;
          end
        end
      end else if (in_en) begin
        sh_p0      <= sh_n_p0;
        col_cnt_p0 <= col_last_p0 ? '0 : col_cnt_p0 + 1'b1;
        if (col_last_p0) begin
          row_cnt_p0 <= row_last_p0 ? '0 : row_cnt_p0 + 1'b1;
        end
        done_p1 <= col_last_p0 && row_last_p0;
        if (rows_full_p0) begin
          vld_p1 <= 1'b1;
          inv_p1 <= border_p0;
          for (int k = 0; k < KERNEL_SIZE; k++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
              win_p1[k][j] <= (ZERO_INVALID && border_p0) ? '0 : sh_n_p0[k][j];
            end
          end
        end
      end
    end
  end

  assign grad_p11     = win_p1[0][0];
  assign grad_p12     = win_p1[1][0];
  assign grad_p13     = win_p1[2][0];
  assign grad_p21     = win_p1[0][1];
  assign grad_p22     = win_p1[1][1];
  assign grad_p23     = win_p1[2][1];
  assign grad_p31     = win_p1[0][2];
  assign grad_p32     = win_p1[1][2];
  assign grad_p33     = win_p1[2][2];
  assign matrix_clken = vld_p1;
  assign data_valid   = inv_p1;
  assign start_sync   = start_p1;
  assign frame_done   = done_p1;

endmodule

// File: tb/tb_grad_matrix_3x3.sv
// Scoreboard bench for grad_matrix_3x3 on a 4x4 frame; expected windows are queued as pixels are driven.
module tb_grad_matrix_3x3;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int DW = 26;

  typedef struct packed {
    logic [3:0]      r;
    logic [3:0]      c;
    logic            dv;
    logic [8:0]      mask;
    logic [9*DW-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_en = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] grad_p11, grad_p12, grad_p13, grad_p21, grad_p22, grad_p23, grad_p31, grad_p32, grad_p33;
  logic matrix_clken, data_valid, start_sync, frame_done;

  int tests = 0, fails = 0, sb_tests = 0, sb_fails = 0;
  int strobe_cnt = 0, valid_cnt = 0, done_cnt = 0;
  int s0, v0, d0;
  logic acc_prev = 1'b0;
  logic [DW-1:0] mdl [D][W];
  logic [DW-1:0] taps [9];
  exp_t sb[$];
  exp_t e;
  int bad;

  grad_matrix_3x3 #(.WIDTH(W), .DEPTH(D), .FIFO_SUM(2), .KERNEL_SIZE(3), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_en(in_en), .in_data(in_data),
    .grad_p11(grad_p11), .grad_p12(grad_p12), .grad_p13(grad_p13),
    .grad_p21(grad_p21), .grad_p22(grad_p22), .grad_p23(grad_p23),
    .grad_p31(grad_p31), .grad_p32(grad_p32), .grad_p33(grad_p33),
    .matrix_clken(matrix_clken), .data_valid(data_valid),
    .start_sync(start_sync), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign taps[0] = grad_p11;
  assign taps[1] = grad_p12;
  assign taps[2] = grad_p13;
  assign taps[3] = grad_p21;
  assign taps[4] = grad_p22;
  assign taps[5] = grad_p23;
  assign taps[6] = grad_p31;
  assign taps[7] = grad_p32;
  assign taps[8] = grad_p33;

  always @(posedge clk) acc_prev <= start && in_en && !rst;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (matrix_clken) begin
      strobe_cnt++;
      if (!data_valid) valid_cnt++;
      sb_tests++;
      if (!acc_prev) begin
        sb_fails++;
        $display("FAIL strobe_without_pixel: matrix_clken=1 at %0t, required 0", $time);
      end
      sb_tests++;
      if (sb.size() == 0) begin
        sb_fails++;
        $display("FAIL unexpected_strobe: strobe at %0t, required none", $time);
      end else begin
        e = sb.pop_front();
        bad = -1;
        for (int k = 0; k < 9; k++)
          if (bad < 0 && e.mask[k] && taps[k] !== e.val[k*DW +: DW]) bad = k;
        if (data_valid !== e.dv || bad >= 0) begin
          sb_fails++;
          if (bad < 0) bad = 0;
          $display("FAIL window_r%0d_c%0d: data_valid=%0b tap%0d=%h, required data_valid=%0b tap%0d=%h",
                   e.r, e.c, data_valid, bad, taps[bad], e.dv, bad, e.val[bad*DW +: DW]);
        end
      end
    end
  end

  task automatic cycle(input logic s, input logic en, input logic [DW-1:0] d);
    start = s; in_en = en; in_data = d;
    @(posedge clk); #1;
  endtask

  function automatic void push_exp(input int r, input int c);
    exp_t x;
    int rr, cc;
    x.r = 4'(r); x.c = 4'(c); x.dv = (c < 2); x.mask = '0; x.val = '0;
    for (int k = 0; k < 9; k++) begin
      rr = r - 2 + k / 3;
      cc = c - 2 + k % 3;
      if (cc < 0) begin cc += W; rr -= 1; end
`ifdef GRAD_MATRIX_ZERO_INVALID_EN
      if (x.dv) begin x.mask[k] = 1'b1; rr = -1; end
`endif
      if (rr >= 0) begin
        x.mask[k] = 1'b1;
        x.val[k*DW +: DW] = mdl[rr][cc];
      end
    end
    sb.push_back(x);
  endfunction

  task automatic send(input int r, input int c, input logic [DW-1:0] d, input int gap);
    for (int g = 0; g < gap; g++) cycle(1'b1, 1'b0, '0);
    mdl[r][c] = d;
    if (r >= 2) push_exp(r, c);
    cycle(1'b1, 1'b1, d);
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit gapped);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < W; c++)
        send(r, c, base + DW'(r * 16 + c), gapped ? int'($urandom_range(3, 0)) : 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    tests++;
    if ({matrix_clken, data_valid, start_sync, frame_done} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 0000", {matrix_clken, data_valid, start_sync, frame_done});
    end
    for (int k = 0; k < 9; k++) begin
      tests++;
      if (taps[k] !== '0) begin fails++; $display("FAIL reset_tap%0d: got %h, required 0", k, taps[k]); end
    end
    rst = 1'b0;
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic test_fill;
    s0 = strobe_cnt; v0 = valid_cnt; d0 = done_cnt;
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r, c, DW'(r * 16 + c), 0);
        tests++;
        if (matrix_clken !== (r >= 2) || (r >= 2 && data_valid !== (c < 2))) begin
          fails++;
          $display("FAIL fill_strobe_r%0d_c%0d: clken=%b dv=%b, required clken=%b dv=%b",
                   r, c, matrix_clken, data_valid, r >= 2, c < 2);
        end
        tests++;
        if (frame_done !== (r == D - 1 && c == W - 1)) begin
          fails++;
          $display("FAIL fill_frame_done_r%0d_c%0d: got %b, required %b", r, c, frame_done, r == D - 1 && c == W - 1);
        end
        if (r == 2 && c == 2) begin
          tests++;
          if ({grad_p11, grad_p13, grad_p22, grad_p31, grad_p33} !== {26'h00, 26'h02, 26'h11, 26'h20, 26'h22}) begin
            fails++;
            $display("FAIL first_valid_window: p11=%h p13=%h p22=%h p31=%h p33=%h, required 00 02 11 20 22",
                     grad_p11, grad_p13, grad_p22, grad_p31, grad_p33);
          end
        end
        if (r == 2 && c == 0) begin
          tests++;
`ifdef GRAD_MATRIX_ZERO_INVALID_EN
          if ({grad_p11, grad_p12, grad_p13, grad_p21, grad_p22, grad_p23, grad_p31, grad_p32, grad_p33} !== '0) begin
            fails++;
            $display("FAIL zero_invalid_taps: p22=%h p33=%h, required all taps 0", grad_p22, grad_p33);
          end
`else
          if ({grad_p33, grad_p32} !== {26'h20, 26'h13}) begin
            fails++;
            $display("FAIL wrapped_window: p33=%h p32=%h, required 20 13", grad_p33, grad_p32);
          end
`endif
        end
      end
    end
  endtask

  task automatic test_frame_wrap;
    cycle(1'b1, 1'b0, '0);
    tests++;
    if (strobe_cnt - s0 != 8 || valid_cnt - v0 != 4) begin
      fails++;
      $display("FAIL frame_strobe_count: strobes=%0d valid=%0d, required 8 4", strobe_cnt - s0, valid_cnt - v0);
    end
    tests++;
    if (done_cnt - d0 != 1 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL frame_done_pulse: pulses=%0d now=%b, required 1 0", done_cnt - d0, frame_done);
    end
    send(0, 0, '0, 0);
    tests++;
    if (matrix_clken !== 1'b0) begin
      fails++;
      $display("FAIL next_frame_p00: clken=%b, required 0", matrix_clken);
    end
    for (int r = 0; r < D; r++)
      for (int c = 0; c < W; c++)
        if (r != 0 || c != 0) send(r, c, DW'(r * 16 + c), 0);
  endtask

  task automatic test_gapped;
    cycle(1'b1, 1'b0, '0);
    s0 = strobe_cnt; v0 = valid_cnt;
    send_frame('0, 1'b1);
    cycle(1'b1, 1'b0, '0);
    tests++;
    if (strobe_cnt - s0 != 8 || valid_cnt - v0 != 4) begin
      fails++;
      $display("FAIL gapped_strobe_count: strobes=%0d valid=%0d, required 8 4", strobe_cnt - s0, valid_cnt - v0);
    end
  endtask

  task automatic test_abort;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (r < 2 || c < 2) send(r, c, 26'h80 + DW'(r * 16 + c), 0);
    cycle(1'b0, 1'b0, '0);
    tests++;
    if ({matrix_clken, data_valid, frame_done} !== 3'b0) begin
      fails++;
      $display("FAIL abort_outputs: clken/dv/done=%b, required 000", {matrix_clken, data_valid, frame_done});
    end
    s0 = strobe_cnt;
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r, c, 26'h100 + DW'(r * 16 + c), 0);
        if (r < 2) begin
          tests++;
          if (matrix_clken !== 1'b0) begin
            fails++;
            $display("FAIL abort_refill_r%0d_c%0d: clken=%b, required 0", r, c, matrix_clken);
          end
        end
        if (r == 2 && c == 2) begin
          tests++;
          if (grad_p22 !== 26'h111 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_first_valid: p22=%h dv=%b, required 111 0", grad_p22, data_valid);
          end
        end
      end
    end
    cycle(1'b1, 1'b0, '0);
    tests++;
    if (strobe_cnt - s0 != 8) begin
      fails++;
      $display("FAIL abort_strobe_count: got %0d, required 8", strobe_cnt - s0);
    end
  endtask

  task automatic test_sync_reset;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 2) send(r, c, 26'h200 + DW'(r * 16 + c), 0);
    rst = 1'b1;
    cycle(1'b1, 1'b1, 26'h232);
    rst = 1'b0;
    tests++;
    if ({matrix_clken, data_valid, start_sync, frame_done} !== 4'b0 ||
        {grad_p11, grad_p12, grad_p13, grad_p21, grad_p22, grad_p23, grad_p31, grad_p32, grad_p33} !== '0) begin
      fails++;
      $display("FAIL midframe_reset: ctrl=%b p22=%h p33=%h, required all 0",
               {matrix_clken, data_valid, start_sync, frame_done}, grad_p22, grad_p33);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 26'h3A0 + DW'(i));
      tests++;
      if ({matrix_clken, data_valid, start_sync, frame_done} !== 4'b0 || grad_p22 !== '0 || grad_p33 !== '0) begin
        fails++;
        $display("FAIL idle_in_en_%0d: ctrl=%b p22=%h p33=%h, required all 0",
                 i, {matrix_clken, data_valid, start_sync, frame_done}, grad_p22, grad_p33);
      end
    end
    s0 = strobe_cnt; v0 = valid_cnt;
    send_frame(26'h300, 1'b0);
    cycle(1'b1, 1'b0, '0);
    tests++;
    if (strobe_cnt - s0 != 8 || valid_cnt - v0 != 4) begin
      fails++;
      $display("FAIL post_reset_count: strobes=%0d valid=%0d, required 8 4", strobe_cnt - s0, valid_cnt - v0);
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_frame_wrap;
    test_gapped;
    test_abort;
    test_sync_reset;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d windows outstanding, required 0", sb.size());
    end
    tests += sb_tests;
    fails += sb_fails;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
